// File: rtl/if_inst_queue_pkg.sv
// Shared constants for the fetch-side instruction queue; mirrors the
// core-wide defines so the queue has no textual include dependency.
package if_inst_queue_pkg;

  localparam logic        BRANCH       = 1'b1;
  localparam logic        NOT_BRANCH   = 1'b0;
  localparam logic        INST_VALID   = 1'b1;
  localparam logic        INST_INVALID = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Queue operation selected for a cycle; flush dominates everything else.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ,
    OP_RW,
    OP_FLUSH
  } q_op_e;

  function automatic q_op_e decode_op(input logic flush, input logic wr, input logic rd);
    if (flush)         return OP_FLUSH;
    else if (wr && rd) return OP_RW;
    else if (wr)       return OP_WRITE;
    else if (rd)       return OP_READ;
    else               return OP_IDLE;
  endfunction

endpackage

// File: rtl/if_inst_queue.sv
// In-order (pc, inst) FIFO between fetch and decode: first-word-fall-through,
// flush on branch redirect, early full so the in-flight fetch always lands.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      pc_i,
  input  logic                       pc_valid_i,
  input  logic [DATA_WIDTH-1:0]      inst_i,
  input  logic                       branch_flag_i,
  input  logic                       stall_i,
  output logic [ADDR_WIDTH-1:0]      pc_o,
  output logic [DATA_WIDTH-1:0]      inst_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               flush;
  logic               not_empty;
  logic               wr_en;
  logic               rd_en;
  logic [ENTRY_W-1:0] head;
  q_op_e              op;

  assign flush     = (branch_flag_i == BRANCH);
  assign not_empty = (count_q != '0);
  assign wr_en     = pc_valid_i && (count_q < CNT_W'(DEPTH)) && !flush;
  assign rd_en     = not_empty && !stall_i && !flush;
  assign op        = decode_op(flush, wr_en, rd_en);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = pc_valid_i && (count_q == CNT_W'(DEPTH)) && !flush;
    unique case (op)
      OP_FLUSH: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      OP_RW: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      OP_WRITE: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
      OP_READ: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; count gates the outputs, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pc_i, inst_i};
  end

  assign head       = mem_q[rd_ptr_q];
  assign pc_o       = not_empty ? head[ENTRY_W-1:DATA_WIDTH] : '0;
  assign inst_o     = not_empty ? head[DATA_WIDTH-1:0]       : '0;
  assign valid_o    = not_empty ? INST_VALID : INST_INVALID;
  // Asserting one entry early leaves room for the fetch already in flight.
  assign full_o     = (count_q >= CNT_W'(DEPTH - 1));
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
